// File: rtl/encoder_8x3_seq_pkg.sv
// Shared types and widths for the sequential 8-to-3 encoder and its priority encoder.
package encoder_8x3_seq_pkg;

   localparam int IDX_W = 3;
   localparam int REQ_W = 8;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

endpackage

// File: rtl/prio_enc_8x3.sv
// Combinational 8-bit priority encoder; msb_first selects which end of the vector wins.
module prio_enc_8x3
   import encoder_8x3_seq_pkg::*;
(
   input  logic [REQ_W-1:0] req,
   input  logic             msb_first,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      idx = '0;
      any = |req;
      if (msb_first) begin
         // Ascending scan: the last set bit seen is the highest one.
         for (int i = 0; i < REQ_W; i++) begin
            if (req[i]) idx = IDX_W'(i);
         end
      end else begin
         for (int i = REQ_W - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: holds pending request flags and hands out their indices
// one per valid/ready transfer in priority order; each accepted index clears its flag.
module encoder_8x3_seq
   import encoder_8x3_seq_pkg::*;
#(
   parameter logic MSB_FIRST = 1'b0,
   parameter int   N         = REQ_W
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REQ_W-1:0] req_in,
   input  logic             req_load,
   input  logic             req_clear,
   output logic [IDX_W-1:0] idx_out,
   output logic             idx_valid,
   input  logic             idx_ready,
   output logic [REQ_W-1:0] pending,
   output logic [3:0]       pend_cnt,
   output logic             done
);

   // Handshake: idx_out transfers at a rising edge where idx_valid and idx_ready are
   // both high; idx_valid never drops and idx_out never changes until that transfer.

   state_t           state, state_n;
   logic             accept;
   logic [REQ_W-1:0] accepted_bit;
   logic [REQ_W-1:0] next_pending;
   logic [REQ_W-1:0] pending_n;
   logic [IDX_W-1:0] idx_n;
   logic [IDX_W-1:0] prio_idx;
   logic             prio_any;
   logic             done_n;
   logic [3:0]       cnt_n;

   assign idx_valid = (state == PRESENT);
   assign accept    = idx_valid & idx_ready;

   always_comb begin
      accepted_bit = '0;
      if (accept) accepted_bit[idx_out] = 1'b1;
      // A bit re-requested while being accepted stays set.
      next_pending = (pending & ~accepted_bit) | (req_load ? req_in : '0);
   end

   prio_enc_8x3 u_prio (
      .req       (next_pending),
      .msb_first (MSB_FIRST),
      .idx       (prio_idx),
      .any       (prio_any)
   );

   always_comb begin
      state_n   = state;
      pending_n = next_pending;
      idx_n     = idx_out;
      done_n    = 1'b0;
      if (req_clear) begin
         state_n   = IDLE;
         pending_n = '0;
         idx_n     = '0;
      end else begin
         case (state)
            IDLE: begin
               if (prio_any) begin
                  state_n = PRESENT;
                  idx_n   = prio_idx;
               end
            end
            PRESENT: begin
               // Without an accept idx_out is held: no preemption by newer requests.
               if (accept) begin
                  if (prio_any) begin
                     idx_n = prio_idx;
                  end else begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_n = '0;
      for (int i = 0; i < N; i++) begin
         cnt_n = cnt_n + {3'b000, pending_n[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pending  <= '0;
         idx_out  <= '0;
         done     <= 1'b0;
         pend_cnt <= '0;
      end else begin
         state    <= state_n;
         pending  <= pending_n;
         idx_out  <= idx_n;
         done     <= done_n;
         pend_cnt <= cnt_n;
      end
   end

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Bench for encoder_8x3_seq: both priority directions against a behavioural model,
// plus directed vectors with hand-computed expectations.
module tb_encoder_8x3_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req_in = 8'h00;
   logic       req_load = 1'b0;
   logic       req_clear = 1'b0;
   logic       idx_ready = 1'b0;

   logic [2:0] d_idx[2];
   logic       d_valid[2];
   logic [7:0] d_pend[2];
   logic [3:0] d_cnt[2];
   logic       d_done[2];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   encoder_8x3_seq #(.MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_load(req_load),
      .req_clear(req_clear), .idx_out(d_idx[0]), .idx_valid(d_valid[0]),
      .idx_ready(idx_ready), .pending(d_pend[0]), .pend_cnt(d_cnt[0]), .done(d_done[0])
   );

   encoder_8x3_seq #(.MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_load(req_load),
      .req_clear(req_clear), .idx_out(d_idx[1]), .idx_valid(d_valid[1]),
      .idx_ready(idx_ready), .pending(d_pend[1]), .pend_cnt(d_cnt[1]), .done(d_done[1])
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_pres holds the index currently offered to the consumer, -1 when nothing is offered.
   logic [7:0] m_pend[2] = '{8'h00, 8'h00};
   int         m_pres[2] = '{-1, -1};
   logic       m_done[2] = '{1'b0, 1'b0};

   function automatic int pick(input logic [7:0] v, input bit msb);
      int r;
      r = -1;
      for (int k = 0; k < 8; k++) begin
         int b;
         b = msb ? 7 - k : k;
         if (r < 0 && v[b]) r = b;
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [7:0] np;
      bit         acc;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            m_pend[d] = 8'h00;
            m_pres[d] = -1;
            m_done[d] = 1'b0;
         end else if (req_clear) begin
            m_pend[d] = 8'h00;
            m_pres[d] = -1;
            m_done[d] = 1'b0;
         end else begin
            acc = (m_pres[d] >= 0) && idx_ready;
            np  = m_pend[d];
            if (acc) np[m_pres[d]] = 1'b0;
            if (req_load) np = np | req_in;
            m_done[d] = acc && (np == 8'h00);
            if (acc || m_pres[d] < 0) m_pres[d] = pick(np, d == 1);
            m_pend[d] = np;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("m%0d_valid", d), d_valid[d], m_pres[d] >= 0);
         if (m_pres[d] >= 0) chk($sformatf("m%0d_idx", d), d_idx[d], m_pres[d]);
         chk($sformatf("m%0d_pending", d), d_pend[d], m_pend[d]);
         chk($sformatf("m%0d_cnt", d), d_cnt[d], $countones(m_pend[d]));
         chk($sformatf("m%0d_done", d), d_done[d], m_done[d]);
      end
   end

   // ---------------- drivers ----------------
   task automatic set_in(input logic ld, input logic [7:0] rin, input logic rdy, input logic clr);
      req_load  = ld;
      req_in    = rin;
      idx_ready = rdy;
      req_clear = clr;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int e_lsb[4];
      int e_msb[4];
      e_lsb = '{1, 2, 4, 7};
      e_msb = '{7, 4, 2, 1};

      // reset state
      tick();
      tick();
      chk("rst_valid", d_valid[0], 0);
      chk("rst_idx", d_idx[0], 0);
      chk("rst_pending", d_pend[0], 0);
      chk("rst_cnt", d_cnt[0], 0);
      chk("rst_done", d_done[0], 0);
      rst_n = 1'b1;
      tick();

      // single request
      set_in(1'b1, 8'b0010_0000, 1'b1, 1'b0);
      tick();
      chk("single_valid", d_valid[0], 1);
      chk("single_idx", d_idx[0], 5);
      chk("single_idx_msb", d_idx[1], 5);
      chk("single_cnt", d_cnt[0], 1);
      set_in(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      chk("single_done", d_done[0], 1);
      chk("single_pend0", d_pend[0], 0);
      chk("single_idle", d_valid[0], 0);
      tick();
      chk("single_done_pulse", d_done[0], 0);

      // back-to-back drain, both directions
      set_in(1'b1, 8'b1001_0110, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) set_in(1'b0, 8'h00, 1'b1, 1'b0);
         chk($sformatf("b2b_idx_%0d", i), d_idx[0], e_lsb[i]);
         chk($sformatf("b2b_idx_msb_%0d", i), d_idx[1], e_msb[i]);
         chk($sformatf("b2b_cnt_%0d", i), d_cnt[0], 4 - i);
         chk($sformatf("b2b_valid_%0d", i), d_valid[0], 1);
         chk($sformatf("b2b_nodone_%0d", i), d_done[0], 0);
      end
      tick();
      chk("b2b_cnt_end", d_cnt[0], 0);
      chk("b2b_done", d_done[0], 1);
      chk("b2b_done_msb", d_done[1], 1);
      tick();
      chk("b2b_done_pulse", d_done[0], 0);

      // backpressure and no preemption
      set_in(1'b1, 8'b1000_0000, 1'b0, 1'b0);
      tick();
      set_in(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("stall_idx_%0d", i), d_idx[0], 7);
      end
      set_in(1'b1, 8'b0000_0001, 1'b0, 1'b0);
      tick();
      chk("nopreempt_idx", d_idx[0], 7);
      chk("nopreempt_pend", d_pend[0], 8'h81);
      chk("nopreempt_cnt", d_cnt[0], 2);
      set_in(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      chk("after_stall_idx", d_idx[0], 0);
      chk("after_stall_nodone", d_done[0], 0);
      tick();
      chk("after_stall_done", d_done[0], 1);
      chk("after_stall_idle", d_valid[0], 0);

      // re-request of the bit being accepted
      set_in(1'b1, 8'b0000_1000, 1'b0, 1'b0);
      tick();
      chk("rereq_idx", d_idx[0], 3);
      set_in(1'b1, 8'b0000_1000, 1'b1, 1'b0);
      tick();
      chk("rereq_valid", d_valid[0], 1);
      chk("rereq_idx2", d_idx[0], 3);
      chk("rereq_pend", d_pend[0], 8'h08);
      chk("rereq_nodone", d_done[0], 0);
      set_in(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      chk("rereq_done", d_done[0], 1);

      // clear beats load
      set_in(1'b1, 8'hFF, 1'b0, 1'b0);
      tick();
      chk("clr_pre_cnt", d_cnt[0], 8);
      chk("clr_pre_idx_msb", d_idx[1], 7);
      set_in(1'b1, 8'hFF, 1'b0, 1'b1);
      tick();
      chk("clr_pend", d_pend[0], 0);
      chk("clr_valid", d_valid[0], 0);
      chk("clr_done", d_done[0], 0);
      chk("clr_cnt", d_cnt[0], 0);
      set_in(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("clr_after_done", d_done[0], 0);

      // asynchronous reset mid-operation
      set_in(1'b1, 8'hFF, 1'b1, 1'b0);
      tick();
      set_in(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      tick();
      chk("midrst_pre_idx", d_idx[0], 2);
      chk("midrst_pre_cnt", d_cnt[0], 6);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", d_valid[0], 0);
      chk("midrst_idx", d_idx[0], 0);
      chk("midrst_pend", d_pend[0], 0);
      chk("midrst_cnt", d_cnt[0], 0);
      chk("midrst_done", d_done[0], 0);
      set_in(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("postrst_valid", d_valid[0], 0);
      chk("postrst_pend", d_pend[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
